// File: rtl/irq_source_ctrl_if.sv
// rtl/irq_source_ctrl_if.sv - interrupt source / core / register bus signals for irq_source_ctrl
interface irq_source_ctrl_if;
    logic [7:0] src_in;
    logic       nmi_src;
    logic       irq_ack;
    logic [2:0] irq_ack_id;
    logic       nmi_ack;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic [7:0] IRQ;
    logic       NMI;
    logic [2:0] irq_id;

    modport master (
        output src_in, nmi_src, irq_ack, irq_ack_id, nmi_ack, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_rdata, IRQ, NMI, irq_id
    );

    modport slave (
        input  src_in, nmi_src, irq_ack, irq_ack_id, nmi_ack, cfg_we, cfg_addr, cfg_wdata,
        output cfg_rdata, IRQ, NMI, irq_id
    );
endinterface

// File: rtl/irq_source_ctrl.sv
// rtl/irq_source_ctrl.sv - interrupt source controller; optional timer on source 7 via IRQ_TIMER_EN
module irq_source_ctrl #(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] RESET_ENABLE = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    irq_source_ctrl_if.slave bus
);
    logic [8:0] sync_q [SYNC_STAGES];
    logic [8:0] hist_q;
    logic [8:0] synced;
    logic [8:0] rise;
    logic [7:0] enable_q;
    logic [7:0] mode_q;
    logic [7:0] pending_q;
    logic [7:0] pending_d;
    logic [7:0] src_level;
    logic [7:0] src_rise;
    logic [7:0] irq;
    logic [2:0] id;
    logic       nmi_q;
    logic       wr_enable;
    logic       wr_pending;
    logic       wr_mode;
    logic [7:0] timer_rd;

    assign synced     = sync_q[SYNC_STAGES-1];
    assign rise       = synced & ~hist_q;
    assign wr_enable  = bus.cfg_we && (bus.cfg_addr == 3'd0);
    assign wr_pending = bus.cfg_we && (bus.cfg_addr == 3'd1);
    assign wr_mode    = bus.cfg_we && (bus.cfg_addr == 3'd2);

    // Bit 8 of the synchroniser chain carries nmi_src.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= {bus.nmi_src, bus.src_in};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            hist_q <= synced;
        end
    end

`ifdef IRQ_TIMER_EN
    logic [15:0] reload_q;
    logic [15:0] cnt_q;
    logic        run_q;
    logic        auto_q;
    logic        timer_fire;

    assign timer_fire = run_q && (cnt_q == 16'd0);
    assign src_level  = {timer_fire, synced[6:0]};
    assign src_rise   = {timer_fire, rise[6:0]};
    assign timer_rd   = (bus.cfg_addr == 3'd4) ? reload_q[7:0]  :
                        (bus.cfg_addr == 3'd5) ? reload_q[15:8] :
                        (bus.cfg_addr == 3'd6) ? {6'd0, auto_q, run_q} : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            auto_q   <= 1'b0;
        end else begin
            if (bus.cfg_we && bus.cfg_addr == 3'd4) reload_q[7:0]  <= bus.cfg_wdata;
            if (bus.cfg_we && bus.cfg_addr == 3'd5) reload_q[15:8] <= bus.cfg_wdata;
            // A control write takes precedence over the running countdown.
            if (bus.cfg_we && bus.cfg_addr == 3'd6) begin
                run_q  <= bus.cfg_wdata[0];
                auto_q <= bus.cfg_wdata[1];
                if (bus.cfg_wdata[0]) cnt_q <= reload_q;
            end else if (run_q) begin
                if (cnt_q == 16'd0) begin
                    if (auto_q) cnt_q <= reload_q;
                    else        run_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 16'd1;
                end
            end
        end
    end
`else
    assign src_level = synced[7:0];
    assign src_rise  = rise[7:0];
    assign timer_rd  = 8'h00;
`endif

    // Edge mode: a set event in the same cycle as a clear wins.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < 8; i++) begin
            if (mode_q[i]) begin
                pending_d[i] = src_level[i];
            end else begin
                pending_d[i] = src_rise[i] |
                    (pending_q[i] & ~((bus.irq_ack && bus.irq_ack_id == 3'(i)) ||
                                      (wr_pending && bus.cfg_wdata[i])));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q  <= RESET_ENABLE;
            mode_q    <= '0;
            pending_q <= '0;
            nmi_q     <= 1'b0;
        end else begin
            if (wr_enable) enable_q <= bus.cfg_wdata;
            if (wr_mode)   mode_q   <= bus.cfg_wdata;
            pending_q <= pending_d;
            if (rise[8])          nmi_q <= 1'b1;
            else if (bus.nmi_ack) nmi_q <= 1'b0;
        end
    end

    assign irq = pending_q & enable_q;

    always_comb begin
        id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (irq[i]) id = 3'(i);
        end
    end

    always_comb begin
        case (bus.cfg_addr)
            3'd0:    bus.cfg_rdata = enable_q;
            3'd1:    bus.cfg_rdata = pending_q;
            3'd2:    bus.cfg_rdata = mode_q;
            3'd3:    bus.cfg_rdata = {|irq, nmi_q, 3'b000, id};
            3'd4,
            3'd5,
            3'd6:    bus.cfg_rdata = timer_rd;
            default: bus.cfg_rdata = 8'h00;
        endcase
    end

    assign bus.IRQ    = irq;
    assign bus.NMI    = nmi_q;
    assign bus.irq_id = id;
endmodule
